// File: rtl/bp_me_lce_req_arbiter_pkg.sv
// Shared constants and helpers for the LCE-to-CCE request arbiter.
package bp_me_lce_req_arbiter_pkg;

    // Default packed bp_lce_cce_req_s width when no configuration is supplied.
    localparam int lce_cce_req_width_gp = 64;
    localparam int grant_count_width_gp = 32;

    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Wraps an index that is known to be below 2*n back into 0..n-1.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? (idx - n) : idx;
    endfunction

endpackage

// File: rtl/bp_me_lce_req_arbiter_chk.sv
// Protocol checker for the arbiter's CCE-side handshake.
module bp_me_lce_req_arbiter_chk (
    input logic clk_i,
    input logic reset_n_i,
    input logic en_i,
    input logic cce_req_v_i,
    input logic cce_req_yumi_i
);

    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i || !en_i)
        cce_req_yumi_i |-> cce_req_v_i)
        else $error("[CHK] cce_req_yumi_i asserted while cce_req_v_o is low");

endmodule

// File: rtl/bp_me_lce_req_fifo.sv
// Per-LCE request buffer: circular buffer with ready/valid input and valid/yumi output.
module bp_me_lce_req_fifo
    import bp_me_lce_req_arbiter_pkg::*;
#(
    parameter int width_p = 8,
    parameter int els_p   = 2
)(
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i
);
    localparam int addr_width_lp = $clog2(els_p);
    localparam int ptr_width_lp  = addr_width_lp + 1;

    logic [ptr_width_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [width_p-1:0]      mem_q [els_p];
    logic                    ready_q, ready_d;
    logic                    enq_s, deq_s, empty_s, full_next_s;

    assign empty_s = (wptr_q == rptr_q);
    assign enq_s   = v_i & ready_q;
    assign deq_s   = yumi_i & ~empty_s;

    // Pointer advance; ready is precomputed from the next pointers so it never depends on this cycle's inputs.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        if (enq_s) begin
            wptr_d = wptr_q + ptr_width_lp'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (deq_s) begin
            rptr_d = rptr_q + ptr_width_lp'(1);
        end else begin
            rptr_d = rptr_q;
        end
        full_next_s = (wptr_d[ptr_width_lp-1] != rptr_d[ptr_width_lp-1])
                   && (wptr_d[addr_width_lp-1:0] == rptr_d[addr_width_lp-1:0]);
        ready_d     = ~full_next_s;
    end

    // Pointer and ready registers; ready stays low while reset is asserted.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            ready_q <= ready_d;
        end
    end

    // Storage array, written only on an accepted enqueue.
    always_ff @(posedge clk_i) begin
        if (enq_s) begin
            mem_q[wptr_q[addr_width_lp-1:0]] <= data_i;
        end
    end

    assign ready_o = ready_q;
    assign v_o     = ~empty_s;
    assign data_o  = mem_q[rptr_q[addr_width_lp-1:0]];

endmodule

// File: rtl/bp_me_lce_req_arbiter.sv
// Buffers each LCE request channel and round-robin arbitrates them onto one CCE request port.
module bp_me_lce_req_arbiter
    import bp_me_lce_req_arbiter_pkg::*;
#(
    parameter int  num_lce_p       = 2,
    parameter int  req_width_p     = lce_cce_req_width_gp,
    parameter int  fifo_els_p      = 2,
    localparam int lce_id_width_lp = safe_clog2(num_lce_p)
)(
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [num_lce_p*req_width_p-1:0] lce_req_i,
    input  logic [num_lce_p-1:0]             lce_req_v_i,
    output logic [num_lce_p-1:0]             lce_req_ready_o,
    output logic [req_width_p-1:0]           cce_req_o,
    output logic [lce_id_width_lp-1:0]       cce_req_lce_id_o,
    output logic                             cce_req_v_o,
    input  logic                             cce_req_yumi_i,
    output logic [31:0]                      grant_count_o
);

    logic [num_lce_p-1:0]       fifo_v_s, fifo_yumi_s;
    logic [req_width_p-1:0]     fifo_data_s [num_lce_p];

    logic [req_width_p-1:0]     req_q, req_d;
    logic [lce_id_width_lp-1:0] id_q, id_d, ptr_q, ptr_d;
    logic                       v_q, v_d;
    logic [31:0]                grant_q, grant_d;

    logic                       load_en_s, found_s;
    logic [2*num_lce_p-1:0]     rot_s;
    int                         start_s, win_int_s;
    logic [lce_id_width_lp-1:0] win_s;
    logic [req_width_p-1:0]     head_s;

    for (genvar i = 0; i < num_lce_p; i++) begin : g_fifo
        bp_me_lce_req_fifo #(
            .width_p (req_width_p),
            .els_p   (fifo_els_p)
        ) fifo_inst (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .data_i    (lce_req_i[i*req_width_p +: req_width_p]),
            .v_i       (lce_req_v_i[i]),
            .ready_o   (lce_req_ready_o[i]),
            .data_o    (fifo_data_s[i]),
            .v_o       (fifo_v_s[i]),
            .yumi_i    (fifo_yumi_s[i])
        );
    end

    // A yumi with nothing valid collapses into an ordinary idle load, so it is harmless.
    assign load_en_s = ~v_q | cce_req_yumi_i;

    // Rotate so the LCE after the last grant lands at bit 0, pick the lowest set bit, rotate back.
    always_comb begin
        start_s   = rr_wrap(int'(ptr_q) + 1, num_lce_p);
        rot_s     = {fifo_v_s, fifo_v_s} >> start_s;
        found_s   = 1'b0;
        win_int_s = 0;
        for (int k = num_lce_p - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                found_s   = 1'b1;
                win_int_s = rr_wrap(start_s + k, num_lce_p);
            end else begin
                found_s   = found_s;
                win_int_s = win_int_s;
            end
        end
        win_s = lce_id_width_lp'(win_int_s);
    end

    // Head-of-queue mux for the winning LCE.
    always_comb begin
        head_s = '0;
        for (int i = 0; i < num_lce_p; i++) begin
            if (win_int_s == i) begin
                head_s = fifo_data_s[i];
            end else begin
                head_s = head_s;
            end
        end
    end

    // Output stage next state: reload on load_en, otherwise hold everything including FIFO heads.
    always_comb begin
        req_d       = req_q;
        id_d        = id_q;
        v_d         = v_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        fifo_yumi_s = '0;
        if (load_en_s) begin
            if (found_s) begin
                req_d   = head_s;
                id_d    = win_s;
                v_d     = 1'b1;
                ptr_d   = win_s;
                grant_d = grant_q + 32'd1;
                for (int i = 0; i < num_lce_p; i++) begin
                    fifo_yumi_s[i] = (win_int_s == i);
                end
            end else begin
                v_d = 1'b0;
            end
        end else begin
            v_d = v_q;
        end
    end

    // Output register; the pointer resets to the last LCE so LCE0 wins first.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            req_q   <= '0;
            id_q    <= '0;
            v_q     <= 1'b0;
            ptr_q   <= lce_id_width_lp'(num_lce_p - 1);
            grant_q <= '0;
        end else begin
            req_q   <= req_d;
            id_q    <= id_d;
            v_q     <= v_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    assign cce_req_o        = req_q;
    assign cce_req_lce_id_o = id_q;
    assign cce_req_v_o      = v_q;
    assign grant_count_o    = grant_q;

endmodule

// File: tb/tb_bp_me_lce_req_arbiter.sv
// Randomized and directed bench for bp_me_lce_req_arbiter against a queue-based reference model.
module tb_bp_me_lce_req_arbiter;

    localparam int W   = 16;
    localparam int NL  = 2;
    localparam int ELS = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          chk_en = 1'b1;

    logic [NL*W-1:0] lce_req = '0;
    logic [NL-1:0]   lce_v = '0;
    logic [NL-1:0]   lce_ready;
    logic [W-1:0]    cce_req;
    logic            cce_id;
    logic            cce_v;
    logic            cce_yumi = 1'b0;
    logic [31:0]     grant;

    logic [4*W-1:0]  lce_req4 = '0;
    logic [3:0]      lce_v4 = '0;
    logic [3:0]      ready4;
    logic [W-1:0]    req4;
    logic [1:0]      id4;
    logic            v4;
    logic            yumi4 = 1'b0;
    logic [31:0]     grant4;

    int tests_run = 0;
    int tests_failed = 0;
    logic [11:0] seq [NL];

    always #5 clk = ~clk;

    bp_me_lce_req_arbiter #(.num_lce_p(NL), .req_width_p(W), .fifo_els_p(ELS)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .lce_req_i(lce_req), .lce_req_v_i(lce_v),
        .lce_req_ready_o(lce_ready), .cce_req_o(cce_req), .cce_req_lce_id_o(cce_id),
        .cce_req_v_o(cce_v), .cce_req_yumi_i(cce_yumi), .grant_count_o(grant)
    );

    bp_me_lce_req_arbiter #(.num_lce_p(4), .req_width_p(W), .fifo_els_p(ELS)) dut4 (
        .clk_i(clk), .reset_n_i(reset_n), .lce_req_i(lce_req4), .lce_req_v_i(lce_v4),
        .lce_req_ready_o(ready4), .cce_req_o(req4), .cce_req_lce_id_o(id4),
        .cce_req_v_o(v4), .cce_req_yumi_i(yumi4), .grant_count_o(grant4)
    );

    bp_me_lce_req_arbiter_chk chk (
        .clk_i(clk), .reset_n_i(reset_n), .en_i(chk_en),
        .cce_req_v_i(cce_v), .cce_req_yumi_i(cce_yumi)
    );

    // Reference model: one queue per LCE, a granted-last id, and the output slot.
    logic [W-1:0] mq [NL][$];
    logic         mdl_v;
    logic [W-1:0] mdl_data;
    logic         mdl_id;
    int           mdl_last;
    logic [31:0]  mdl_grant;
    logic [NL-1:0] mdl_ready;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NL; i++) mq[i].delete();
            mdl_v     <= 1'b0;
            mdl_data  <= '0;
            mdl_id    <= 1'b0;
            mdl_last  <= NL - 1;
            mdl_grant <= '0;
            mdl_ready <= '0;
        end else begin : step
            int w;
            w = -1;
            if (!mdl_v || cce_yumi) begin
                for (int k = 1; k <= NL; k++) begin
                    if (w < 0 && mq[(mdl_last + k) % NL].size() > 0) w = (mdl_last + k) % NL;
                end
                if (w >= 0) begin
                    mdl_data  <= mq[w].pop_front();
                    mdl_id    <= w[0];
                    mdl_v     <= 1'b1;
                    mdl_last  <= w;
                    mdl_grant <= mdl_grant + 32'd1;
                end else begin
                    mdl_v <= 1'b0;
                end
            end
            for (int i = 0; i < NL; i++) begin
                if (lce_v[i] && mdl_ready[i]) mq[i].push_back(lce_req[i*W +: W]);
            end
            for (int i = 0; i < NL; i++) mdl_ready[i] <= (mq[i].size() < ELS);
        end
    end

    // One clock of the main DUT, compared against the model on the following negedge.
    task automatic tick(input logic want_yumi);
        logic [NL-1:0] hs;
        for (int i = 0; i < NL; i++) lce_req[i*W +: W] = {4'(i), seq[i]};
        cce_yumi = want_yumi & mdl_v;
        hs = lce_v & mdl_ready;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NL; i++) if (hs[i]) seq[i] = seq[i] + 12'd1;
        tests_run++;
        if (cce_v !== mdl_v) begin
            tests_failed++;
            $display("FAIL tick_v t=%0t got %b exp %b", $time, cce_v, mdl_v);
        end
        tests_run++;
        if (grant !== mdl_grant) begin
            tests_failed++;
            $display("FAIL tick_grant t=%0t got %0d exp %0d", $time, grant, mdl_grant);
        end
        tests_run++;
        if (lce_ready !== mdl_ready) begin
            tests_failed++;
            $display("FAIL tick_ready t=%0t got %b exp %b", $time, lce_ready, mdl_ready);
        end
        if (mdl_v) begin
            tests_run++;
            if (cce_req !== mdl_data || cce_id !== mdl_id) begin
                tests_failed++;
                $display("FAIL tick_out t=%0t got id%0d %h exp id%0d %h", $time, cce_id, cce_req, mdl_id, mdl_data);
            end
        end
    endtask

    task automatic do_reset();
        lce_v = '0; cce_yumi = 1'b0; lce_v4 = '0; yumi4 = 1'b0;
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick(1'b0);
    endtask

    task automatic test_reset();
        lce_v = 2'b11;
        @(posedge clk); @(posedge clk); @(negedge clk);
        tests_run++;
        if (lce_ready !== 2'b00 || cce_v !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready_v got %b/%b exp 00/0", lce_ready, cce_v);
        end
        tests_run++;
        if (cce_req !== '0 || cce_id !== 1'b0 || grant !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_out got %h/%b/%0d exp 0/0/0", cce_req, cce_id, grant);
        end
        reset_n = 1'b1;
        tick(1'b0);
        tests_run++;
        if (lce_ready !== 2'b11) begin
            tests_failed++;
            $display("FAIL reset_first_ready got %b exp 11", lce_ready);
        end
        tick(1'b0);
        tick(1'b0);
        tests_run++;
        if (cce_v !== 1'b1 || cce_id !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_first_grant got v%b id%0d exp v1 id0", cce_v, cce_id);
        end
        lce_v = '0;
    endtask

    task automatic test_single_lce();
        logic [W-1:0] exp_d [3];
        logic [W-1:0] got_d [$];
        logic         got_id [$];
        do_reset();
        for (int j = 0; j < 3; j++) exp_d[j] = {4'd1, seq[1] + 12'(j)};
        lce_v = 2'b10;
        for (int t = 0; t < 6; t++) begin
            if (t == 3) lce_v = 2'b00;
            tick(1'b1);
            if (cce_v) begin got_d.push_back(cce_req); got_id.push_back(cce_id); end
        end
        tests_run++;
        if (got_d.size() != 3) begin
            tests_failed++;
            $display("FAIL single_count got %0d exp 3", got_d.size());
        end else begin
            for (int j = 0; j < 3; j++) begin
                tests_run++;
                if (got_d[j] !== exp_d[j] || got_id[j] !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL single_order[%0d] got id%0d %h exp id1 %h", j, got_id[j], got_d[j], exp_d[j]);
                end
            end
        end
        tests_run++;
        if (grant !== 32'd3) begin
            tests_failed++;
            $display("FAIL single_grant got %0d exp 3", grant);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp_first;
        int ids [$];
        do_reset();
        exp_first = {4'd0, seq[0]};
        lce_v = 2'b11;
        for (int t = 0; t < 5; t++) tick(1'b0);
        tests_run++;
        if (cce_v !== 1'b1 || cce_id !== 1'b0 || cce_req !== exp_first || lce_ready !== 2'b00) begin
            tests_failed++;
            $display("FAIL bp_hold got v%b id%0d %h rdy%b exp v1 id0 %h rdy00", cce_v, cce_id, cce_req, lce_ready, exp_first);
        end
        lce_v = 2'b00;
        for (int t = 0; t < 7; t++) begin
            if (cce_v) ids.push_back(int'(cce_id));
            tick(1'b1);
        end
        tests_run++;
        if (ids.size() != 5) begin
            tests_failed++;
            $display("FAIL bp_drain_count got %0d exp 5", ids.size());
        end else begin
            for (int j = 0; j < 5; j++) begin
                tests_run++;
                if (ids[j] != j % 2) begin
                    tests_failed++;
                    $display("FAIL bp_drain_id[%0d] got %0d exp %0d", j, ids[j], j % 2);
                end
            end
        end
    endtask

    task automatic test_four_lce();
        do_reset();
        tests_run++;
        if (ready4 !== 4'b1111) begin
            tests_failed++;
            $display("FAIL four_ready_init got %b exp 1111", ready4);
        end
        for (int e = 0; e < 2; e++) begin
            for (int i = 0; i < 4; i++) lce_req4[i*W +: W] = {4'(i), 12'(e)};
            lce_v4 = 4'b1111;
            @(posedge clk); @(negedge clk);
        end
        lce_v4 = 4'b0000;
        tests_run++;
        if (ready4 !== 4'b0001) begin
            tests_failed++;
            $display("FAIL four_ready_full got %b exp 0001", ready4);
        end
        yumi4 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tests_run++;
            if (v4 !== 1'b1 || id4 !== 2'(k % 4) || req4 !== {4'(k % 4), 12'(k / 4)}) begin
                tests_failed++;
                $display("FAIL four_rr[%0d] got v%b id%0d %h exp v1 id%0d %h", k, v4, id4, req4, k % 4, {4'(k % 4), 12'(k / 4)});
            end
            @(posedge clk); @(negedge clk);
        end
        yumi4 = 1'b0;
        tests_run++;
        if (v4 !== 1'b0 || grant4 !== 32'd8) begin
            tests_failed++;
            $display("FAIL four_end got v%b grant%0d exp v0 grant8", v4, grant4);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int t = 0; t < 20; t++) begin
            lce_v = 2'($urandom_range(0, 3));
            tick(1'b1);
        end
        #3;
        reset_n = 1'b0;
        lce_v = '0;
        cce_yumi = 1'b0;
        #1;
        tests_run++;
        if (cce_v !== 1'b0 || grant !== 32'd0 || lce_ready !== 2'b00) begin
            tests_failed++;
            $display("FAIL async_reset got v%b grant%0d rdy%b exp v0 grant0 rdy00", cce_v, grant, lce_ready);
        end
        @(posedge clk); @(negedge clk);
        reset_n = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick(1'b1);
            tests_run++;
            if (cce_v !== 1'b0) begin
                tests_failed++;
                $display("FAIL async_stale[%0d] got v%b id%0d %h exp v0", t, cce_v, cce_id, cce_req);
            end
        end
    endtask

    task automatic test_illegal_yumi();
        lce_v = '0;
        chk_en = 1'b0;
        cce_yumi = 1'b1;
        @(posedge clk); @(negedge clk);
        cce_yumi = 1'b0;
        chk_en = 1'b1;
        tests_run++;
        if (cce_v !== 1'b0 || grant !== mdl_grant || lce_ready !== 2'b11) begin
            tests_failed++;
            $display("FAIL illegal_yumi got v%b grant%0d rdy%b exp v0 grant%0d rdy11", cce_v, grant, lce_ready, mdl_grant);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 400; t++) begin
            lce_v = 2'($urandom_range(0, 3));
            tick(1'($urandom_range(0, 1)));
        end
        lce_v = '0;
        for (int t = 0; t < 8; t++) tick(1'b1);
    endtask

    initial begin
        for (int i = 0; i < NL; i++) seq[i] = 12'd0;
        test_reset();
        test_single_lce();
        test_backpressure();
        test_four_lce();
        test_async_reset();
        test_illegal_yumi();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
